// File: rtl/clk_div_en_multi.sv
// Multi-channel programmable clock-enable generator: each channel emits single-cycle
// enable pulses with its own divide ratio, phase offset and periodic/one-shot mode.
module clk_div_en_multi #(
    parameter int CH          = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 16,
    localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_oneshot,
    input  logic [CH-1:0]    run,
    input  logic             sync_start,
    output logic [CH-1:0]    en,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    // Phase is clipped so the first pulse never lands later than one full period.
    function automatic logic [DIV_W-1:0] eff_ph(input logic [DIV_W-1:0] d,
                                               input logic [DIV_W-1:0] p);
        logic [DIV_W-1:0] dm1;
        dm1 = eff_div(d) - ONE;
        return (p > dm1) ? dm1 : p;
    endfunction

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        state_t           state_reg, state_next;
        logic [DIV_W-1:0] cnt_reg, cnt_next;
        logic [DIV_W-1:0] act_div_reg, act_div_next, act_ph_reg, act_ph_next;
        logic             act_os_reg, act_os_next;
        logic [DIV_W-1:0] sh_div_reg, sh_div_next, sh_ph_reg, sh_ph_next;
        logic             sh_os_reg, sh_os_next;
        logic             pend_reg, pend_next;
        logic             en_reg, en_next;
        logic [DIV_W-1:0] ld_div, ld_ph;
        logic             ld_os;
        logic             wr_hit;
        logic             busy_c, done_c;

        assign wr_hit = cfg_wr && (cfg_ch == CHW'(gi));

        // Config that becomes active at a period boundary (shadow if a write is pending).
        assign ld_div = pend_reg ? sh_div_reg : act_div_reg;
        assign ld_ph  = pend_reg ? sh_ph_reg  : act_ph_reg;
        assign ld_os  = pend_reg ? sh_os_reg  : act_os_reg;

        always_ff @(posedge clk_in) begin
            if (!rst_n) begin
                state_reg   <= S_IDLE;
                cnt_reg     <= '0;
                act_div_reg <= DIV_W'(DEFAULT_DIV);
                act_ph_reg  <= '0;
                act_os_reg  <= 1'b0;
                sh_div_reg  <= DIV_W'(DEFAULT_DIV);
                sh_ph_reg   <= '0;
                sh_os_reg   <= 1'b0;
                pend_reg    <= 1'b0;
                en_reg      <= 1'b0;
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                act_div_reg <= act_div_next;
                act_ph_reg  <= act_ph_next;
                act_os_reg  <= act_os_next;
                sh_div_reg  <= sh_div_next;
                sh_ph_reg   <= sh_ph_next;
                sh_os_reg   <= sh_os_next;
                pend_reg    <= pend_next;
                en_reg      <= en_next;
            end
        end

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            act_div_next = act_div_reg;
            act_ph_next  = act_ph_reg;
            act_os_next  = act_os_reg;
            sh_div_next  = sh_div_reg;
            sh_ph_next   = sh_ph_reg;
            sh_os_next   = sh_os_reg;
            pend_next    = pend_reg;
            en_next      = 1'b0;

            if (wr_hit) begin
                sh_div_next = cfg_div;
                sh_ph_next  = cfg_phase;
                sh_os_next  = cfg_oneshot;
                if (state_reg == S_RUN) begin
                    pend_next = 1'b1;
                end else begin
                    act_div_next = cfg_div;
                    act_ph_next  = cfg_phase;
                    act_os_next  = cfg_oneshot;
                end
            end

            if (!run[gi]) begin
                state_next = S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        state_next = S_RUN;
                        cnt_next   = wr_hit ? eff_ph(cfg_div, cfg_phase)
                                            : eff_ph(act_div_reg, act_ph_reg);
                    end
                    S_RUN: begin
                        if (sync_start || cnt_reg == '0) begin
                            act_div_next = ld_div;
                            act_ph_next  = ld_ph;
                            act_os_next  = ld_os;
                            if (!wr_hit) pend_next = 1'b0;
                            if (sync_start) begin
                                cnt_next = eff_ph(ld_div, ld_ph);
                            end else begin
                                en_next = 1'b1;
                                if (ld_os) state_next = S_DONE;
                                else       cnt_next = eff_div(ld_div) - ONE;
                            end
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            busy_c = (state_reg == S_RUN);
            done_c = (state_reg == S_DONE);
        end

        assign en[gi]   = en_reg;
        assign busy[gi] = busy_c;
        assign done[gi] = done_c;
    end

endmodule

// File: tb/tb_clk_div_en_multi.sv
// Bench for clk_div_en_multi: an absolute-time pulse model checks every cycle, and
// directed scenarios pin exact pulse positions.
module tb_clk_div_en_multi;

    localparam int CH    = 4;
    localparam int DIV_W = 16;
    localparam int DEFD  = 16;
    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int DONE  = 2;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [DIV_W-1:0] cfg_phase = '0;
    logic             cfg_oneshot = 1'b0;
    logic [CH-1:0]    run = '0;
    logic             sync_start = 1'b0;
    logic [CH-1:0]    en, busy, done;

    clk_div_en_multi #(.CH(CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFD)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_oneshot(cfg_oneshot),
        .run(run), .sync_start(sync_start), .en(en), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    // Model: channel state plus the absolute edge index of the next pulse.
    int m_st [CH];
    int a_d [CH], a_p [CH], a_os [CH];
    int s_d [CH], s_p [CH], s_os [CH];
    int pend [CH];
    int nf [CH];
    bit m_en [CH];

    logic [63:0] hist [CH];

    function automatic int effd(int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int effp(int d, int p);
        int dd = effd(d);
        return (p > dd - 1) ? dd - 1 : p;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic model_update();
        tcyc++;
        for (int c = 0; c < CH; c++) begin
            bit wr  = cfg_wr && (int'(cfg_ch) == c);
            int old = m_st[c];
            m_en[c] = 1'b0;
            if (!rst_n) begin
                m_st[c] = IDLE; pend[c] = 0; nf[c] = 0;
                a_d[c] = DEFD; a_p[c] = 0; a_os[c] = 0;
                s_d[c] = DEFD; s_p[c] = 0; s_os[c] = 0;
                continue;
            end
            if (wr && old != RUN) begin
                a_d[c] = int'(cfg_div); a_p[c] = int'(cfg_phase); a_os[c] = int'(cfg_oneshot);
                s_d[c] = a_d[c];        s_p[c] = a_p[c];          s_os[c] = a_os[c];
            end
            if (!run[c]) begin
                m_st[c] = IDLE;
            end else if (old == IDLE) begin
                m_st[c] = RUN;
                nf[c] = tcyc + effp(a_d[c], a_p[c]) + 1;
            end else if (old == RUN) begin
                bit hit = sync_start || (tcyc == nf[c]);
                if (hit && pend[c] != 0) begin
                    a_d[c] = s_d[c]; a_p[c] = s_p[c]; a_os[c] = s_os[c];
                    pend[c] = 0;
                end
                if (sync_start) begin
                    nf[c] = tcyc + effp(a_d[c], a_p[c]) + 1;
                end else if (hit) begin
                    m_en[c] = 1'b1;
                    if (a_os[c] != 0) m_st[c] = DONE;
                    else              nf[c] = tcyc + effd(a_d[c]);
                end
            end
            if (wr && old == RUN) begin
                s_d[c] = int'(cfg_div); s_p[c] = int'(cfg_phase); s_os[c] = int'(cfg_oneshot);
                pend[c] = 1;
            end
        end
    endtask

    task automatic compare();
        logic [CH-1:0] e_en, e_busy, e_done;
        for (int c = 0; c < CH; c++) begin
            e_en[c]   = m_en[c];
            e_busy[c] = (m_st[c] == RUN);
            e_done[c] = (m_st[c] == DONE);
        end
        check("en", 64'(en), 64'(e_en));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
        compare();
        cfg_wr = 1'b0;
        sync_start = 1'b0;
    endtask

    task automatic record(int n);
        for (int c = 0; c < CH; c++) hist[c] = '0;
        for (int j = 0; j < n; j++) begin
            step();
            for (int c = 0; c < CH; c++) hist[c][j] = en[c];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_cfg(int ch, int d, int p, bit os);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_div = DIV_W'(d);
        cfg_phase = DIV_W'(p); cfg_oneshot = os;
    endtask

    initial begin
        do_reset();
        check("reset_outputs", {en, busy, done}, 64'h0);

        // Defaults: D=16, P=0.
        run[0] = 1'b1; step();
        record(40);
        check("defaults_ch0", hist[0][39:0], 64'h00_0001_0001_0001 & 64'hFF_FFFF_FFFF);
        check("defaults_busy", 64'(busy), 64'h1);
        check("defaults_other", hist[1] | hist[2] | hist[3], 64'h0);

        // Idle write D=3 P=2 on ch1.
        do_reset();
        write_cfg(1, 3, 2, 1'b0); step();
        run[1] = 1'b1; step();
        record(12);
        check("ch1_d3p2", hist[1][11:0], 64'h924);

        // Runtime divide change mid-period.
        do_reset();
        run[0] = 1'b1; step();
        for (int k = 0; k < 8; k++) step();
        write_cfg(0, 5, 0, 1'b0);
        record(20);
        check("div_change", hist[0][19:0], 64'h42100);

        // D=0 clamps to 1; P clipped to D'-1.
        do_reset();
        write_cfg(2, 0, 0, 1'b0); step();
        write_cfg(3, 4, 7, 1'b0); step();
        run[2] = 1'b1; run[3] = 1'b1; step();
        record(12);
        check("ch2_d0", hist[2][11:0], 64'hFFF);
        check("ch3_pclip", hist[3][11:0], 64'h888);

        // One-shot, then re-arm via run low/high.
        do_reset();
        write_cfg(2, 4, 0, 1'b1); step();
        run[2] = 1'b1; step();
        record(10);
        check("oneshot", hist[2][9:0], 64'h001);
        check("oneshot_done", 64'(done[2]), 64'h1);
        check("oneshot_busy", 64'(busy[2]), 64'h0);
        run[2] = 1'b0; step();
        check("oneshot_clear", 64'(done[2]), 64'h0);
        run[2] = 1'b1; step();
        record(6);
        check("oneshot_rearm", hist[2][5:0], 64'h01);

        // sync_start aligns two out-of-step channels, then reset mid-run.
        do_reset();
        write_cfg(0, 6, 0, 1'b0); step();
        write_cfg(1, 6, 0, 1'b0); step();
        run[0] = 1'b1; step(); step(); step();
        run[1] = 1'b1; step(); step();
        sync_start = 1'b1; step();
        check("sync_low", 64'(en[1:0]), 64'h0);
        record(14);
        check("sync_ch0", hist[0][13:0], 64'h1041);
        check("sync_ch1", hist[1][13:0], 64'h1041);
        rst_n = 1'b0; step();
        check("midrun_reset", {en, busy, done}, 64'h0);
        rst_n = 1'b1; step();
        record(20);
        check("reset_div16", hist[0][19:0], 64'h10001);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 19) == 0) run[c] = ~run[c];
            if ($urandom_range(0, 3) == 0) begin
                write_cfg(int'($urandom_range(0, 3)),
                          ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 300))
                                                       : int'($urandom_range(0, 9)),
                          int'($urandom_range(0, 10)), ($urandom_range(0, 4) == 0));
            end
            sync_start = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_en_multi.md
# clk_div_en_multi

Multi-channel programmable clock-enable generator: produces CH independent single-cycle enable pulses from one clock, each with a runtime-programmable divide ratio, phase offset and periodic/one-shot mode. It replaces fixed-ratio enable dividers wherever several rate strobes are needed, for example UART bit ticks, scan pacing or LED refresh in the verify platform controller. Configuration changes are glitch-free: they take effect only at period boundaries. A global sync restart aligns all running channels.

## Interface
- CH, 4, number of channels (≥1)
- DIV_W, 16, width of divide/phase fields (≥2)
- DEFAULT_DIV, 16, reset divide ratio for every channel (1 ≤ DEFAULT_DIV < 2^DIV_W)
- CHW, max(1,$clog2(CH)), width of cfg_ch (derived, not overridden)

- clk_in  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_wr  in  1  config write strobe, one write per cycle
- cfg_ch  in  CHW  target channel; values ≥CH are ignored
- cfg_div  in  DIV_W  divide ratio D
- cfg_phase  in  DIV_W  phase offset P
- cfg_oneshot  in  1  0 = periodic, 1 = one-shot
- run  in  CH  per-channel level enable
- sync_start  in  1  single-cycle pulse that restarts all running channels
- en  out  CH  registered single-cycle enable pulses
- busy  out  CH  channel in RUN
- done  out  CH  one-shot channel has fired

## Operation
- Per channel there is a shadow config (D, P, mode), an active config, a pending flag, a down-counter cnt[DIV_W] and a state machine IDLE/RUN/DONE.
- Effective values: D' = max(D,1); P' = min(P, D'−1).
- Reset, sampled on the clk_in edge with rst_n=0:
  - active and shadow: D=DEFAULT_DIV, P=0, mode periodic
  - pending=0, cnt=0, state IDLE
  - en, busy and done all 0
- cfg_wr while the channel is IDLE or DONE: shadow and active are both written at the same edge.
- cfg_wr while the channel is RUN: only the shadow is written and pending is set. At the next wrap, active loads from the shadow as it stood before that edge, and pending clears. A write landing on the same edge as a wrap applies at the following wrap.
- IDLE→RUN on the edge sampling run[i]=1: cnt←P' and busy←1. If cfg_wr targets the channel on that same edge, the written values are used.
- RUN, cnt≠0: cnt←cnt−1, en←0.
- RUN, cnt=0 (wrap): en←1.
  - Periodic: cnt←D'−1, using the newly active D if pending.
  - One-shot: state←DONE, busy←0, done←1.
- DONE: en←0, counter held. It is exited only when run[i] is sampled 0.
- run[i] sampled 0 in any state: state←IDLE and en, busy, done←0 on that edge. Re-assertion restarts from phase; the previous count is not retained.
- sync_start sampled 1: every channel in RUN sets cnt←P' and en←0, and any pending shadow is applied first. sync_start takes priority over a wrap on the same edge. IDLE and DONE channels are unaffected.
- Channel arithmetic is modulo nothing: the counter never exceeds D'−1, and there is no overflow path.

## Timing
- Start edge T: first en pulse appears after edge T+P'+1, then every D' cycles, each pulse exactly 1 cycle wide.
- With D'=1, en stays continuously high while running, starting after edge T+1.
- After sync_start at edge S: en is low after S, and the next pulse follows edge S+P'+1.
- A runtime divide change: the current period completes with the old D, and the next period uses the new D.
- en, busy and done are all registered outputs with no combinational path from inputs.
- Reset mid-operation: all outputs are 0 after the reset edge, and config reverts to defaults.

## Test plan
- Reset, then run[0]=1 at edge T with defaults → en[0] high after T+1, T+17, T+33; busy[0]=1; other channels stay 0.
- Idle write ch1 D=3 P=2, then run[1] → en[1] after T+3, T+6, T+9.
- ch0 running D=16; write D=5 mid-period (cnt=8) → the next pulse is 9 cycles later, then every 5.
- ch2 D=0 → en[2] constantly high. ch3 D=4 P=7 → P clipped to 3; first pulse after T+4, period 4.
- ch2 one-shot D=4 P=0 → one pulse after T+1; done=1, busy=0 and no further pulses. Then run=0 → done=0; run=1 → one new pulse.
- ch0 and ch1 both D=6 P=0 but out of step; sync_start at S → both pulse after S+1, S+7, aligned. Then rst_n=0 mid-run → en, busy and done =0 next edge, and D reverts to 16.
